// File: rtl/uart_tx_cfg.sv
// UART transmitter with compile-time frame format. Define UART_TX_CFG_FIFO_EN to add a transmit FIFO.
// states: IDLE line high, waiting | START low bit | DATA payload LSB first | PAR parity | STOP high bit(s)
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS-1:0]        data_to_send,
    input  logic                        valid,
    output logic                        ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] load_data;
    logic                 par_bit;
    logic                 rdy_en;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 avail;
    logic                 load;

    assign bit_end   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data = (bit_idx == BIT_W'(DATA_BITS - 1));
    assign last_stop = (STOP_BITS == 2) ? stop_idx : 1'b1;
    assign load      = (state_next == START) && (state != START);

`ifdef UART_TX_CFG_FIFO_EN
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]     count;
    logic                 push;

    assign ready     = rdy_en && (count != LVL_W'(FIFO_DEPTH));
    assign push      = valid && ready;
    assign avail     = (count != '0);
    assign load_data = mem[rd_ptr];
    assign level     = count;

    // storage has no reset; pointers and count alone define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_to_send;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    assign ready     = rdy_en && (state == IDLE);
    assign avail     = valid && ready;
    assign load_data = data_to_send;
    assign level     = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (avail) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && last_data) state_next = (PARITY != 0) ? PAR : STOP;
            PAR:   if (bit_end) state_next = STOP;
            STOP: begin
                if (bit_end && last_stop) begin
`ifdef UART_TX_CFG_FIFO_EN
                    state_next = avail ? START : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state != IDLE);
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            PAR:     tx = par_bit;
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en   <= 1'b0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;

            if (state == IDLE || bit_end) clk_cnt <= '0;
            else                          clk_cnt <= clk_cnt + 1'b1;

            if (state != DATA) bit_idx <= '0;
            else if (bit_end)  bit_idx <= bit_idx + 1'b1;

            if (state != STOP) stop_idx <= 1'b0;
            else if (bit_end)  stop_idx <= ~stop_idx;

            // payload and its parity are captured once so mid-frame input changes are ignored
            if (load) begin
                shreg   <= load_data;
                par_bit <= (^load_data) ^ (PARITY == 1);
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three differently configured instances checked every cycle against a frame-level model,
// plus hand-computed waveform points. Follows UART_TX_CFG_FIFO_EN the same way the design does.
module tb_uart_tx_cfg;

`ifdef UART_TX_CFG_FIFO_EN
    localparam int LAT      = 2;
    localparam int STOP_RUN = 6;
`else
    localparam int LAT      = 1;
    localparam int STOP_RUN = 7;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld    [3];
    logic [8:0] dat    [3];
    logic       tx_o   [3];
    logic       busy_o [3];
    logic       rdy_o  [3];
    logic [2:0] lvl_o  [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .data_to_send(dat[0][7:0]), .valid(vld[0]),
        .ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]), .level(lvl_o[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .data_to_send(dat[1][6:0]), .valid(vld[1]),
        .ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]), .level(lvl_o[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .data_to_send(dat[2][4:0]), .valid(vld[2]),
        .ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]), .level(lvl_o[2]));

    function automatic int cpb(input int k);  return (k == 2) ? 3 : 4; endfunction
    function automatic int dbits(input int k); return (k == 0) ? 8 : ((k == 1) ? 7 : 5); endfunction
    function automatic int pmode(input int k); return (k == 0) ? 2 : ((k == 1) ? 1 : 0); endfunction
    function automatic int sbits(input int k); return (k == 2) ? 2 : 1; endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    endtask

    // model: each instance is a line that replays a whole frame, one bit per cpb cycles
    bit          started;
    int          cyc_left [3];
    int          flen     [3];
    logic [15:0] frame    [3];
`ifdef UART_TX_CFG_FIFO_EN
    int          fcnt     [3];
    logic [8:0]  fq       [3][4];
`endif

    function automatic logic [15:0] build_frame(input int k, input logic [8:0] w);
        logic [15:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < dbits(k); i++) begin
            f[1+i] = w[i];
            p      = p ^ w[i];
        end
        if (pmode(k) == 1) p = ~p;
        if (pmode(k) != 0) f[1+dbits(k)] = p;
        return f;
    endfunction

    function automatic int frame_len(input int k);
        return 1 + dbits(k) + ((pmode(k) != 0) ? 1 : 0) + sbits(k);
    endfunction

    function automatic logic exp_tx(input int k);
        if (cyc_left[k] == 0) return 1'b1;
        return frame[k][(flen[k] * cpb(k) - cyc_left[k]) / cpb(k)];
    endfunction

    function automatic logic exp_ready(input int k);
`ifdef UART_TX_CFG_FIFO_EN
        return started && (fcnt[k] != 4);
`else
        return started && (cyc_left[k] == 0);
`endif
    endfunction

    function automatic int exp_level(input int k);
`ifdef UART_TX_CFG_FIFO_EN
        return fcnt[k];
`else
        return (k < 0) ? 1 : 0;
`endif
    endfunction

    task automatic model_clear();
        started = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc_left[k] = 0;
`ifdef UART_TX_CFG_FIFO_EN
            fcnt[k] = 0;
`endif
        end
    endtask

    task automatic model_load(input int k, input logic [8:0] w);
        frame[k]    = build_frame(k, w);
        flen[k]     = frame_len(k);
        cyc_left[k] = flen[k] * cpb(k);
    endtask

    task automatic model_step();
        logic acc;
        int   pre_left;
        for (int k = 0; k < 3; k++) begin
            acc      = vld[k] && exp_ready(k);
            pre_left = cyc_left[k];
            if (cyc_left[k] > 0) cyc_left[k]--;
`ifdef UART_TX_CFG_FIFO_EN
            if (pre_left <= 1 && fcnt[k] > 0) begin
                model_load(k, fq[k][0]);
                for (int j = 0; j < 3; j++) fq[k][j] = fq[k][j+1];
                fcnt[k]--;
            end
            if (acc) begin
                fq[k][fcnt[k]] = dat[k];
                fcnt[k]++;
            end
`else
            if (acc && pre_left == 0) model_load(k, dat[k]);
`endif
        end
        started = 1'b1;
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            if (!rst_n) model_clear();
            else        model_step();
            @(negedge clk);
            if (!rst_n) model_clear();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("tx_u%0d", k),    tx_o[k],   exp_tx(k));
                chk($sformatf("busy_u%0d", k),  busy_o[k], cyc_left[k] != 0);
                chk($sformatf("ready_u%0d", k), rdy_o[k],  exp_ready(k));
                chk($sformatf("level_u%0d", k), lvl_o[k],  exp_level(k));
            end
        end
    endtask

    // 0xA5 with even parity on the wire: 0,1,0,1,0,0,1,0,1,0,1 (bit 0 first)
    function automatic logic a5_bit(input int i);
        logic [10:0] s;
        s = 11'b10101001010;
        return s[i];
    endfunction

    task automatic send_one(input int k, input logic [8:0] w, output int lat);
        dat[k] = w;
        vld[k] = 1'b1;
        @(negedge clk);
        vld[k] = 1'b0;
        lat = 1;
        while (tx_o[k] !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("start_seen_u%0d", k), tx_o[k], 0);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (busy_o[k] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_reached_u%0d", k), busy_o[k], 0);
    endtask

    initial begin
        logic [15:0] lf;
        int          lat;
        int          run;
        int          acc;
        int          nb;

        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            dat[k] = '0;
        end
        model_clear();
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_tx", tx_o[0], 1);
        chk("reset_busy", busy_o[0], 0);
        chk("reset_ready", rdy_o[0], 0);
        chk("reset_level", lvl_o[0], 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", rdy_o[0], 0);
        @(negedge clk);
        chk("ready_after_first_edge", rdy_o[0], 1);

        lf = build_frame(0, 9'h0A5);
        for (int i = 0; i < 11; i++) chk("model_a5_frame", lf[i], a5_bit(i));
        chk("model_a5_cycles", frame_len(0) * cpb(0), 44);
        lf = build_frame(1, 9'h001);
        chk("model_odd_par_01", lf[8], 0);
        lf = build_frame(1, 9'h003);
        chk("model_odd_par_03", lf[8], 1);

        // 0xA5, even parity, 4 clocks per bit
        send_one(0, 9'h0A5, lat);
        chk("a5_latency", lat, LAT);
        for (int c = 0; c < 44; c++) begin
            chk("a5_tx", tx_o[0], a5_bit(c / 4));
            @(negedge clk);
        end
        chk("a5_done_busy", busy_o[0], 0);
        chk("a5_done_tx", tx_o[0], 1);

        // odd parity, 7 data bits: parity period spans cycles 32..35 after the start bit
        send_one(1, 9'h001, lat);
        repeat (33) @(negedge clk);
        chk("odd_par_01", tx_o[1], 0);
        wait_idle(1);
        send_one(1, 9'h003, lat);
        repeat (33) @(negedge clk);
        chk("odd_par_03", tx_o[1], 1);
        wait_idle(1);

        // two stop bits: payload MSB is 0 so the high run after it is stop bits plus any idle gap
        dat[2] = 9'h00F;
        vld[2] = 1'b1;
`ifdef UART_TX_CFG_FIFO_EN
        @(negedge clk);
        @(negedge clk);
        vld[2] = 1'b0;
`endif
        lat = 0;
        while (tx_o[2] !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("sb2_first_start", tx_o[2], 0);
        repeat (15) @(negedge clk);
        chk("sb2_last_data_bit", tx_o[2], 0);
        repeat (3) @(negedge clk);
        run = 0;
        while (tx_o[2] === 1'b1 && run < 20) begin
            @(negedge clk);
            run++;
        end
        vld[2] = 1'b0;
        chk("sb2_high_run", run, STOP_RUN);
        chk("sb2_second_start", tx_o[2], 0);
        wait_idle(2);

`ifdef UART_TX_CFG_FIFO_EN
        // five words offered with valid held high into a 4-deep FIFO
        vld[0] = 1'b1;
        acc = 0;
        nb  = 0;
        while (acc < 5 && nb < 50) begin
            dat[0] = 9'h030 + 9'(acc);
            if (rdy_o[0] === 1'b1) acc++;
            @(negedge clk);
            nb++;
        end
        vld[0] = 1'b0;
        chk("fifo_pushes", acc, 5);
        chk("fifo_full_level", lvl_o[0], 4);
        chk("fifo_full_ready", rdy_o[0], 0);
        nb = 0;
        while (busy_o[0] === 1'b1 && nb < 400) begin
            @(negedge clk);
            nb++;
        end
        chk("fifo_b2b_busy_cycles", nb, 217);
`else
        // valid held high with data changing every cycle: one acceptance per 45-cycle period
        vld[0] = 1'b1;
        acc = 0;
        for (int c = 0; c < 135; c++) begin
            dat[0] = 9'(c);
            if (rdy_o[0] === 1'b1) acc++;
            @(negedge clk);
        end
        vld[0] = 1'b0;
        chk("hold_valid_accepts", acc, 3);
`endif
        wait_idle(0);

        // reset in the middle of a 0x00 payload
        send_one(0, 9'h000, lat);
        repeat (10) @(negedge clk);
        chk("pre_reset_tx", tx_o[0], 0);
        chk("pre_reset_busy", busy_o[0], 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_tx", tx_o[0], 1);
        chk("reset_async_busy", busy_o[0], 0);
        chk("reset_async_ready", rdy_o[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("post_reset_level", lvl_o[0], 0);
        @(negedge clk);
        chk("post_reset_ready", rdy_o[0], 1);

        // 0x5A after reset: data bit0 = 0 in cycles 4..7, bit1 = 1 in cycles 8..11
        send_one(0, 9'h05A, lat);
        chk("post_reset_latency", lat, LAT);
        repeat (5) @(negedge clk);
        chk("post_reset_bit0", tx_o[0], 0);
        repeat (4) @(negedge clk);
        chk("post_reset_bit1", tx_o[0], 1);
        wait_idle(0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per bit period (legal range 2..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal range 5..9).
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode (0 none, 1 odd, 2 even).
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1, 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries (power of 2, range 2..64).
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-008 SHALL have port data_to_send, input, DATA_BITS wide, meaning the payload word.
REQ-009 SHALL have port valid, input, 1 bit, meaning the producer is offering data_to_send.
REQ-010 SHALL have port ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-011 SHALL have port tx, output, 1 bit, meaning the serial line, which idles high.
REQ-012 SHALL have port busy, output, 1 bit, meaning a frame is in progress (state not IDLE).
REQ-013 SHALL have port level, output, $clog2(FIFO_DEPTH)+1 bits wide, meaning the current FIFO occupancy.

Function
REQ-014 SHALL accept a word only on a rising clk edge where valid && ready are both high; valid without ready leaves all state unchanged.
REQ-015 SHALL implement the states IDLE, START, DATA, PAR and STOP.
REQ-016 SHALL drive tx as follows: IDLE 1; START 0; DATA current bit, LSB first; PAR parity bit; STOP 1.
REQ-017 SHALL hold each START, DATA, PAR and STOP bit for exactly CLKS_PER_BIT cycles, using a bit counter that clears on every state or bit change.
REQ-018 SHALL take transitions IDLE->START on a word available; START->DATA; DATA->DATA until bit DATA_BITS-1 completes; then DATA->PAR if PARITY!=0, else DATA->STOP.
REQ-019 SHALL complete STOP after STOP_BITS bit periods, then go to START if another word is available, else to IDLE (no idle gap between back-to-back frames).
REQ-020 SHALL compute the parity bit as XOR of the payload for even mode and as its inverse for odd mode.
REQ-021 SHALL give each frame a length of (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-022 SHALL latch the payload into a shift register on entering START, so that input changes mid-frame have no effect on tx.
REQ-023 SHALL treat an unlisted state value as IDLE on the next cycle.

Reset
REQ-024 SHALL, while rst_n is low, asynchronously force state=IDLE, tx=1, ready=0, busy=0, level=0, FIFO pointers=0 and all counters=0.
REQ-025 SHALL abort a frame in progress when reset is asserted, with tx returning high immediately and the FIFO contents discarded.
REQ-026 SHALL raise ready no earlier than the first clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL compile the FIFO in when macro UART_TX_CFG_FIFO_EN is defined: ready = (level != FIFO_DEPTH); a push and pop in the same cycle leave level unchanged; the first word into an empty, idle block reaches START 2 cycles after acceptance.
REQ-028 SHALL, when UART_TX_CFG_FIFO_EN is undefined, omit the FIFO: ready=1 only in IDLE, level is tied to 0, and an accepted word enters START on the next cycle (1-cycle latency), with no back-to-back path.

Verification
REQ-029 SHALL cover: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles, 44 cycles total.
REQ-030 SHALL cover: PARITY=1, DATA_BITS=7, send 0x01 -> parity bit 0; same setup sending 0x03 -> parity bit 1.
REQ-031 SHALL cover: with FIFO_EN and FIFO_DEPTH=4, push 5 words with valid held high -> ready drops after the 4th push and level=4; frames appear back-to-back with no idle-high gap beyond the stop bits.
REQ-032 SHALL cover: STOP_BITS=2 -> tx stays high for 2*CLKS_PER_BIT cycles before the next start bit.
REQ-033 SHALL cover: assert rst_n=0 mid-DATA -> tx=1 and busy=0 in the same cycle without waiting for a clk edge; after release, level=0 and the next accepted word transmits correctly.
REQ-034 SHALL cover: without FIFO_EN, hold valid high continuously -> ready pulses only in IDLE, and exactly one frame is sent per acceptance.
